macrow_fir: RTL

- Parametrised successor to the fixed 4-tap MAC row. Streaming N-tap FIR built from a row of signed fixed-point MACs: y[t] = sat(Σk W[k]·x[t−k] >> FRAC).
- Adds addressed weight loading into a shadow bank with atomic commit, a history clear, and saturation with an overflow flag.
- Sits between the sample source and the next array row.

---
 rtl/macrow_fir_if.sv | 26 ++
 rtl/macrow_fir.sv | 99 +++++++++
 2 files changed

// File: rtl/macrow_fir_if.sv
// Bus bundle for macrow_fir: weight load port, sample input and filtered output.
interface macrow_fir_if #(
   parameter int DW = 16,
   parameter int AW = 2
);
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          w_commit;
   logic          clr;
   logic          x_valid;
   logic [DW-1:0] x_data;
   logic          y_valid;
   logic [DW-1:0] y_data;
   logic          y_ovf;

   modport master (
      output w_we, w_addr, w_data, w_commit, clr, x_valid, x_data,
      input  y_valid, y_data, y_ovf
   );

   modport slave (
      input  w_we, w_addr, w_data, w_commit, clr, x_valid, x_data,
      output y_valid, y_data, y_ovf
   );
endinterface

// File: rtl/macrow_fir.sv
// Streaming N-tap signed fixed-point FIR: product row, then sum/shift/saturate.
// Weights load into a shadow bank and move to the active bank on commit.
module macrow_fir #(
   parameter int N_TAPS = 4,
   parameter int DW     = 16,
   parameter int FRAC   = 8,
   parameter int AW     = $clog2(N_TAPS),
   parameter int ACC_W  = 2*DW+AW
) (
   input logic        clk,
   input logic        reset,
   macrow_fir_if.slave bus
);
   typedef logic signed [DW-1:0]   smp_t;
   typedef logic signed [2*DW-1:0] prd_t;

   localparam logic signed [ACC_W-1:0] Y_MAX =
      {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN =
      {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   smp_t shadow [N_TAPS];
   smp_t active [N_TAPS];
   smp_t shadow_nxt [N_TAPS];
   smp_t hist [N_TAPS-1];
   smp_t hist_eff [N_TAPS-1];
   prd_t prod [N_TAPS];
   logic v1;
   logic addr_ok;
   logic take;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] r;

   assign addr_ok = int'(bus.w_addr) < N_TAPS;
   assign take    = v1 && !bus.clr;

   // Same-edge write is folded in so a commit captures it.
   always_comb begin
      for (int k = 0; k < N_TAPS; k++) shadow_nxt[k] = shadow[k];
      if (bus.w_we && addr_ok) shadow_nxt[bus.w_addr] = bus.w_data;
   end

   always_comb begin
      for (int k = 0; k < N_TAPS-1; k++)
         hist_eff[k] = bus.clr ? '0 : hist[k];
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < N_TAPS; k++)
         acc = acc + {{AW{prod[k][2*DW-1]}}, prod[k]};
      r = acc >>> FRAC;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
            prod[k]   <= '0;
         end
         for (int k = 0; k < N_TAPS-1; k++) hist[k] <= '0;
         v1          <= 1'b0;
         bus.y_valid <= 1'b0;
         bus.y_data  <= '0;
         bus.y_ovf   <= 1'b0;
      end else begin
         for (int k = 0; k < N_TAPS; k++) shadow[k] <= shadow_nxt[k];
         if (bus.w_commit)
            for (int k = 0; k < N_TAPS; k++) active[k] <= shadow_nxt[k];

         v1 <= bus.x_valid;
         if (bus.x_valid) begin
            prod[0] <= $signed(bus.x_data) * active[0];
            for (int k = 1; k < N_TAPS; k++)
               prod[k] <= hist_eff[k-1] * active[k];
            hist[0] <= bus.x_data;
            for (int k = 1; k < N_TAPS-1; k++) hist[k] <= hist_eff[k-1];
         end else if (bus.clr) begin
            for (int k = 0; k < N_TAPS-1; k++) hist[k] <= '0;
         end

         // clr drops the result still sitting in the product row.
         bus.y_valid <= take;
         if (take) begin
            if (r > Y_MAX) begin
               bus.y_data <= Y_MAX[DW-1:0];
               bus.y_ovf  <= 1'b1;
            end else if (r < Y_MIN) begin
               bus.y_data <= Y_MIN[DW-1:0];
               bus.y_ovf  <= 1'b1;
            end else begin
               bus.y_data <= r[DW-1:0];
               bus.y_ovf  <= 1'b0;
            end
         end
      end
   end
endmodule
